// File: rtl/pipelined_adder_if.sv
// Handshake bundle for pipelined_adder: operand side (in_*, A, B, c_in)
// and result side (out_*, S, C_out, ovf). master = producer/consumer, slave = adder.
interface pipelined_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             C_out;
    logic             ovf;

    modport master (
        output in_valid,
        output A,
        output B,
        output c_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  S,
        input  C_out,
        input  ovf
    );

    modport slave (
        input  in_valid,
        input  A,
        input  B,
        input  c_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output S,
        output C_out,
        output ovf
    );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder: one WIDTH/STAGES-bit slice per stage, carry
// registered between slices, valid/ready on both ends, full throughput.
// Ports: clk, rst (sync, active high), bus (pipelined_adder_if.slave).
// Option: define PIPELINED_ADDER_OVF_EN to register a signed-overflow flag;
// otherwise bus.ovf is tied low.
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    pipelined_adder_if.slave bus
);
    localparam int SW  = WIDTH / STAGES;
    localparam int L   = STAGES - 1;
    // Operand skew registers only feed stages 1..L.
    localparam int NSK = (STAGES > 1) ? STAGES - 1 : 1;

    // Per-stage state
    logic [STAGES-1:0] r_vld;
    logic [STAGES-1:0] r_cy;
    logic [WIDTH-1:0]  r_sum [STAGES];
    logic [WIDTH-1:0]  r_a   [NSK];
    logic [WIDTH-1:0]  r_b   [NSK];

    // Stage inputs and next-state values
    logic [STAGES-1:0] w_vld_in;
    logic [STAGES-1:0] w_cy_in;
    logic [STAGES-1:0] w_cy_nxt;
    logic [WIDTH-1:0]  w_a_in    [STAGES];
    logic [WIDTH-1:0]  w_b_in    [STAGES];
    logic [WIDTH-1:0]  w_sum_in  [STAGES];
    logic [WIDTH-1:0]  w_sum_nxt [STAGES];
    logic [SW:0]       w_res     [STAGES];
    logic              w_adv;

    // The whole pipe moves together; it only freezes when the
    // output holds a result the consumer is not taking.
    assign w_adv        = ~r_vld[L] | bus.out_ready;
    assign bus.in_ready = w_adv;

    assign bus.out_valid = r_vld[L];
    assign bus.S         = r_sum[L];
    assign bus.C_out     = r_cy[L];

    always_comb begin
        w_vld_in[0] = bus.in_valid;
        w_cy_in[0]  = bus.c_in;
        w_a_in[0]   = bus.A;
        w_b_in[0]   = bus.B;
        w_sum_in[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            w_vld_in[k] = r_vld[k-1];
            w_cy_in[k]  = r_cy[k-1];
            w_a_in[k]   = r_a[k-1];
            w_b_in[k]   = r_b[k-1];
            w_sum_in[k] = r_sum[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            w_res[k] = {1'b0, w_a_in[k][k*SW +: SW]}
                     + {1'b0, w_b_in[k][k*SW +: SW]}
                     + {{SW{1'b0}}, w_cy_in[k]};
            // Lower slices already done ride along; slice k is filled here.
            w_sum_nxt[k]               = w_sum_in[k];
            w_sum_nxt[k][k*SW +: SW]   = w_res[k][SW-1:0];
            w_cy_nxt[k]                = w_res[k][SW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            r_cy  <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_sum[k] <= '0;
            end
        end else if (w_adv) begin
            r_vld <= w_vld_in;
            r_cy  <= w_cy_nxt;
            for (int k = 0; k < STAGES; k++) begin
                r_sum[k] <= w_sum_nxt[k];
            end
        end
    end

    // Operands are only needed to feed later slices; no reset required
    // because they are qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            for (int k = 0; k < L; k++) begin
                r_a[k] <= w_a_in[k];
                r_b[k] <= w_b_in[k];
            end
        end
    end

`ifdef PIPELINED_ADDER_OVF_EN
    logic r_ovf;
    logic w_ovf_nxt;

    // Signs come from the operands of the word entering the last stage,
    // so the flag is aligned with the sum it describes.
    assign w_ovf_nxt =
        (w_a_in[L][WIDTH-1] == w_b_in[L][WIDTH-1]) &
        (w_sum_nxt[L][WIDTH-1] != w_a_in[L][WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            r_ovf <= w_ovf_nxt;
        end
    end

    assign bus.ovf = r_ovf;
`else
    assign bus.ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=16, STAGES=4):
// queue-based reference model plus directed literal checks.
module tb_pipelined_adder;
    localparam int W  = 16;
    localparam int ST = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipelined_adder_if #(.WIDTH(W)) bus ();

    pipelined_adder #(.WIDTH(W), .STAGES(ST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic         ovf;
        logic         c;
        logic [W-1:0] s;
    } res_t;

    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];
    res_t e_res;
    res_t held_v;
    logic held = 1'b0;

`ifdef PIPELINED_ADDER_OVF_EN
    localparam logic OVF1 = 1'b1;
`else
    localparam logic OVF1 = 1'b0;
`endif

    logic [W-1:0] va [8] = '{16'h1234, 16'hFFFF, 16'h8000, 16'h0F0F,
                             16'hAAAA, 16'h0001, 16'h7FFF, 16'hC3C3};
    logic [W-1:0] vb [8] = '{16'h4321, 16'h0000, 16'h8000, 16'hF0F0,
                             16'h5555, 16'hFFFF, 16'h7FFF, 16'h3C3D};
    logic         vc [8] = '{1'b1, 1'b0, 1'b1, 1'b0,
                             1'b1, 1'b0, 1'b0, 1'b1};

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   input logic ci);
        logic [W:0] t;
        res_t r;
        t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        r.s = t[W-1:0];
        r.c = t[W];
`ifdef PIPELINED_ADDER_OVF_EN
        r.ovf = (a[W-1] == b[W-1]) && (r.s[W-1] != a[W-1]);
`else
        r.ovf = 1'b0;
`endif
        return r;
    endfunction

    // Compare process: every transfer, every stall hold, no spurious output.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            held = 1'b0;
        end else begin
            if (held) begin
                chk("stall_valid", {31'b0, bus.out_valid}, 1);
                chk("stall_hold", {14'b0, bus.ovf, bus.C_out, bus.S},
                    {14'b0, held_v});
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", {31'b0, bus.out_valid}, 0);
                end else begin
                    e_res = exp_q.pop_front();
                    chk("result", {14'b0, bus.ovf, bus.C_out, bus.S},
                        {14'b0, e_res});
                end
            end
            held   = bus.out_valid && !bus.out_ready;
            held_v = {bus.ovf, bus.C_out, bus.S};
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.A, bus.B, bus.c_in));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.A        = '0;
        bus.B        = '0;
        bus.c_in     = 1'b0;
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci);
        bus.in_valid = 1'b1;
        bus.A        = a;
        bus.B        = b;
        bus.c_in     = ci;
    endtask

    task automatic single(input string nm, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic ci,
                          input logic [W-1:0] es, input logic ec,
                          input logic eo);
        int n;
        bus.out_ready = 1'b1;
        chk({nm, "_in_ready"}, {31'b0, bus.in_ready}, 1);
        drive(a, b, ci);
        step();
        idle();
        n = 1;
        while (!bus.out_valid && n < 12) begin
            step();
            n++;
        end
        chk({nm, "_latency"}, n, ST);
        chk({nm, "_S"}, {16'b0, bus.S}, {16'b0, es});
        chk({nm, "_C_out"}, {31'b0, bus.C_out}, {31'b0, ec});
        chk({nm, "_ovf"}, {31'b0, bus.ovf}, {31'b0, eo});
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int first;
        int cnt;
        int last;
        int idx;
        int c;
        int seen;
        logic acc;

        idle();
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (2) step();
        chk("rst_out_valid", {31'b0, bus.out_valid}, 0);
        chk("rst_S", {16'b0, bus.S}, 0);
        chk("rst_C_out", {31'b0, bus.C_out}, 0);
        chk("rst_ovf", {31'b0, bus.ovf}, 0);
        chk("rst_in_ready", {31'b0, bus.in_ready}, 1);
        rst = 1'b0;
        step();

        single("basic",   16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
        single("ripple1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        single("ripple2", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        single("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, OVF1);
        single("ovf_neg", 16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, OVF1);

        // Back-to-back stream, consumer always ready.
        first = -1;
        cnt   = 0;
        last  = -1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i < 8) drive(va[i], vb[i], vc[i]);
            else       idle();
            step();
            if (bus.out_valid) begin
                if (first < 0) first = i + 1;
                cnt++;
                last = i + 1;
            end
        end
        chk("stream_first", first, ST);
        chk("stream_count", cnt, 8);
        chk("stream_last", last, ST + 7);

        // Backpressure: consumer stalls, then releases.
        idx = 0;
        c   = 0;
        while (idx < 8 && c < 60) begin
            drive(va[idx], vb[7-idx], vc[7-idx]);
            bus.out_ready = (c >= 12);
            @(negedge clk);
            acc = bus.in_valid & bus.in_ready;
            if (c == 10) begin
                chk("bp_in_ready", {31'b0, bus.in_ready}, 0);
                chk("bp_out_valid", {31'b0, bus.out_valid}, 1);
                chk("bp_accepted", idx, 4);
            end
            step();
            if (acc) idx++;
            c++;
        end
        chk("bp_all_sent", idx, 8);
        idle();
        bus.out_ready = 1'b1;
        c = 0;
        while (exp_q.size() > 0 && c < 20) begin
            step();
            c++;
        end
        chk("bp_drained", exp_q.size(), 0);
        step();
        chk("bp_empty", {31'b0, bus.out_valid}, 0);

        // Reset with three words in flight.
        for (int i = 0; i < 3; i++) begin
            drive(va[i], vb[i], vc[i]);
            step();
        end
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_out_valid", {31'b0, bus.out_valid}, 0);
        chk("mid_rst_S", {16'b0, bus.S}, 0);
        chk("mid_rst_C_out", {31'b0, bus.C_out}, 0);
        seen = 0;
        repeat (6) begin
            step();
            if (bus.out_valid) seen++;
        end
        chk("mid_rst_no_output", seen, 0);
        single("post_rst", 16'h0102, 16'h0304, 1'b1, 16'h0407, 1'b0, 1'b0);

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
